regfile_dump_reader: RTL
========================

// Module: regfile_dump_reader
// PURPOSE
//  Sequential reader on the register file's read port: on start, walks register indices
//  first..NUM_REGS-1 on rr1, captures each rd1 value and streams (index, data) words out
//  over a valid/ready handshake. Used for debug dumps and end-of-test state checks.
//  Muxed onto rr1 only while busy=1.
// PARAMETERS
//  NUM_REGS  32  registers to walk; indices 0..NUM_REGS-1
//  ADDR_W    5   width of read-register index (clog2(NUM_REGS))
//  DATA_W    32  register data width
//  SKIP_X0   0   1: start at index 1 (x0 hard-wired zero); 0: start at index 0
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       begin dump; sampled only in IDLE
//  abort      in   1       synchronous cancel; priority over all but reset
//  rr_addr    out  ADDR_W  register index to regfile rr1
//  rd_data    in   DATA_W  regfile rd1 (regfile updates it on negedge clk)
//  out_valid  out  1       out_data/out_idx/out_last hold a word
//  out_ready  in   1       consumer accepts word when out_valid&&out_ready at posedge
//  out_data   out  DATA_W  captured register value
//  out_idx    out  ADDR_W  index of out_data
//  out_last   out  1       word is final index NUM_REGS-1
//  busy       out  1       1 in any state other than IDLE
//  done       out  1       one-cycle pulse after last word accepted
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; rr_addr=0, out_valid=0, out_data=0, out_idx=0,
//   out_last=0, busy=0, done=0. Reset mid-dump discards the dump; no word is emitted.
//  States: IDLE, WAIT, SEND, DONE. first = SKIP_X0 ? 1 : 0.
//  IDLE: start=1 -> rr_addr<=first, idx<=first, ->WAIT. start ignored in all other states.
//  WAIT: exactly one cycle; regfile captures rd1 at the intervening negedge. Next posedge:
//   out_data<=rd_data, out_idx<=idx, out_last<=(idx==NUM_REGS-1), out_valid<=1, ->SEND.
//  SEND: out_valid=1; out_data/out_idx/out_last held stable until accepted.
//   accept && !out_last: out_valid<=0, idx<=idx+1, rr_addr<=idx+1, ->WAIT.
//   accept && out_last:  out_valid<=0, out_last<=0, done<=1, ->DONE.
//  DONE: done=1 for this cycle only; -> IDLE next posedge (busy still 1 in DONE).
//  Latency: start to first out_valid = 2 posedges; min 2 cycles/word (WAIT+SEND);
//   full dump with out_ready=1: 2*(NUM_REGS-first)+1 cycles start->done pulse.
//  abort=1 in WAIT/SEND/DONE: ->IDLE, out_valid<=0, out_last<=0, done<=0; in-flight word
//   dropped; no done pulse. abort in IDLE: no effect. abort and start together: IDLE stays.
//  out_ready while out_valid=0: ignored. idx never wraps; NUM_REGS-1 terminates.
//  Snapshot not atomic: a regfile write during a dump is seen iff it lands before
//   the WAIT cycle of that index.
// TESTING
//  Preload reg[i]=32'hA000_0000+i, SKIP_X0=0, out_ready=1, pulse start -> 32 words idx
//   0..31 with matching data, out_last only on idx 31, done pulse exactly 65 cycles after start.
//  SKIP_X0=1 -> first word idx 1, 31 words total, done after 63 cycles.
//  out_ready held 0 for 5 cycles at idx 7 -> out_valid/out_data/out_idx stable all 5
//   cycles; idx 8 follows 2 cycles after out_ready rises.
//  abort asserted while out_valid=1 at idx 12 -> next cycle busy=0, out_valid=0, no done;
//   new start dumps from idx 0 correctly.
//  rst_n low mid-WAIT (idx 20), async between edges -> outputs all 0 immediately; start
//   pulse while busy (idx 3) ignored, dump continues unchanged.
//  Regfile write reg[10]=32'hDEAD_BEEF while SEND holds idx 5 -> idx 10 word reads DEADBEEF.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Handshake and regfile read-port bundle for the register dump reader.
// The reader side uses the master modport; the consumer/regfile side uses slave.
interface regfile_dump_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] rr_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_idx;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      input  start, abort, rd_data, out_ready,
      output rr_addr, out_valid, out_data, out_idx, out_last, busy, done
   );

   modport slave (
      output start, abort, rd_data, out_ready,
      input  rr_addr, out_valid, out_data, out_idx, out_last, busy, done
   );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file read port and streams (index, data) words out.
// One WAIT cycle per index lets the regfile settle rd1 at the negedge.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int SKIP_X0  = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   regfile_dump_reader_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_e;

   localparam logic [ADDR_W-1:0] FIRST =
      (SKIP_X0 != 0) ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] rr_addr_q, rr_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_idx_q, out_idx_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic              accept;

   assign accept = out_valid_q && bus.out_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: abort beats everything, start only counts in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (bus.start && !bus.abort) state_d = S_WAIT;
         S_WAIT: state_d = bus.abort ? S_IDLE : S_SEND;
         S_SEND: begin
            if (bus.abort)       state_d = S_IDLE;
            else if (accept)     state_d = out_last_q ? S_DONE : S_WAIT;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; word held stable while SEND waits
   always_comb begin
      idx_d       = idx_q;
      rr_addr_d   = rr_addr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               idx_d     = FIRST;
               rr_addr_d = FIRST;
            end
         end
         S_WAIT: begin
            if (bus.abort) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else begin
               out_data_d  = bus.rd_data;
               out_idx_d   = idx_q;
               out_last_d  = (idx_q == LAST);
               out_valid_d = 1'b1;
            end
         end
         S_SEND: begin
            if (bus.abort) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else if (accept && !out_last_q) begin
               out_valid_d = 1'b0;
               idx_d       = idx_q + ADDR_W'(1);
               rr_addr_d   = idx_q + ADDR_W'(1);
            end else if (accept) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               done_d      = 1'b1;
            end
         end
         S_DONE: begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
         default: begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         rr_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         rr_addr_q   <= rr_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign bus.rr_addr   = rr_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule
